led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//   Output stage directly downstream of the LED pattern generator: consumes its
//   8-bit LED8 pattern and drives the physical LEDs with PWM brightness.
//   Global brightness is adjustable by up/down pulses. Each channel lights at
//   full set brightness while its input is 1, then fades out linearly after it drops.
//   Gives a visible afterglow trail on running-light patterns.
// PARAMETERS
//   PWM_BITS  4   width of PWM counter, brightness and per-channel duty (MAX = 2^PWM_BITS-1)
//   FADE_DIV  16  clk cycles per fade step (>=1); one duty decrement per step
// PORTS
//   clk        in   1         system clock, rising edge
//   reset      in   1         asynchronous, active-high; clears all state
//   led_in     in   8         pattern from LED generator (LED8), synchronous to clk
//   bright_up  in   1         single-cycle pulse: brightness +1
//   bright_dn  in   1         single-cycle pulse: brightness -1
//   led_out    out  8         PWM-modulated LED drive, registered
//   fading     out  1         registered; 1 while any channel has led_in=0 and duty>0
// BEHAVIOUR
//   Reset (async, immediate): pwm_cnt=0, fade prescaler=0, bright=MAX, duty[7:0]=0,
//     led_out=8'h00, fading=0. Assertion mid-fade aborts the fade at once.
//   pwm_cnt: PWM_BITS wide, +1 every clk, wraps MAX->0 (period 2^PWM_BITS cycles).
//   Prescaler: counts 0..FADE_DIV-1 and wraps; fade_tick=1 for the one cycle where
//     count==FADE_DIV-1 (every FADE_DIV cycles; FADE_DIV=1 -> every cycle).
//   bright: up alone -> +1, saturate at MAX; dn alone -> -1, saturate at 0;
//     up and dn same cycle -> unchanged. Takes effect on the edge the pulse is sampled.
//   duty[i], per edge, priority order:
//     1. led_in[i]=1 -> duty[i] <= bright (new bright if changing same edge).
//     2. else fade_tick and duty[i]>0 -> duty[i] <= min(duty[i]-1, bright).
//     3. else duty[i] <= min(duty[i], bright). Brightness drop clamps glowing channels.
//     Never wraps below 0.
//   led_out[i] <= (duty[i]==MAX) | (pwm_cnt < duty[i]), evaluated on current duty.
//     duty 0 -> always off; duty MAX -> always on; duty d -> d high cycles per PWM period.
//   fading <= |(~led_in & duty-nonzero vector), from current duty and led_in.
//   Latency: led_in[i] rise sampled at edge k -> duty[i] valid after k ->
//     led_out[i] reflects it after edge k+1 (2 edges). Same latency for bright changes.
//   led_in re-asserted during fade reloads duty to bright immediately (no fade-in).
//   Full fade from MAX to 0 takes MAX*FADE_DIV cycles, +/- FADE_DIV by phase.
//   All 8 channels independent; the PWM counter and prescaler are shared.
// TESTING (PWM_BITS=4, FADE_DIV=4 unless noted)
//   1. Release reset, led_in=8'h01 held -> from 2nd edge led_out=8'h01 continuously;
//      fading=0.
//   2. led_in=8'h01, 8 bright_dn pulses -> bright=7; led_out[0] high exactly 7 of
//      every 16 cycles (pwm_cnt 0..6).
//   3. bright=15, led_in 8'h01->8'h00 -> duty[0] 15,14,..,0, one step per 4 cycles;
//      fading=1 during fade, led_out[0]=0 and fading=0 within 64 cycles.
//   4. 20 bright_up at bright=15 -> stays 15; 20 bright_dn -> 0, led_out=0 with led_in=FF;
//      up+dn same cycle -> unchanged.
//   5. Mid-fade (duty[0]=8) assert reset between edges -> led_out=00, fading=0
//      before next edge; after release bright=15.
//   6. led_in walking 1 (01,02,..,80), one step per 8 cycles -> trailing channels
//      show decreasing duties; re-hit channel reloads to 15.

Source files
------------

// File: rtl/led_fade_driver.sv
// PWM LED output stage with global brightness and linear per-channel fade-out.
// Output lags led_in by two edges; no backpressure, consumes led_in every cycle.
module led_fade_driver #(
  parameter int PWM_BITS = 4,
  parameter int FADE_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led_in,
  input  logic       bright_up,
  input  logic       bright_dn,
  output logic [7:0] led_out,
  output logic       fading
);

  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam int                  PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [PWM_BITS-1:0]      r_pwm_cnt;
  logic [PRE_W-1:0]         r_pre;
  logic [PWM_BITS-1:0]      r_bright;
  logic [7:0][PWM_BITS-1:0] r_duty;
  logic [7:0]               r_led_out;
  logic                     r_fading;

  logic                     w_fade_tick;
  logic [PWM_BITS-1:0]      w_bright_nxt;
  logic [PWM_BITS-1:0]      w_base;
  logic [7:0][PWM_BITS-1:0] w_duty_nxt;
  logic [7:0]               w_led_nxt;
  logic [7:0]               w_glow;

  assign w_fade_tick = (r_pre == PRE_LAST);

  always_comb begin
    w_bright_nxt = r_bright;
    if (bright_up && !bright_dn && (r_bright != MAX)) begin
      w_bright_nxt = r_bright + PWM_BITS'(1);
    end else if (bright_dn && !bright_up && (r_bright != '0)) begin
      w_bright_nxt = r_bright - PWM_BITS'(1);
    end
  end

  // Non-lit channels are clamped to the new brightness so a dimming step
  // pulls glowing channels down immediately.
  always_comb begin
    w_base     = '0;
    w_duty_nxt = r_duty;
    w_led_nxt  = '0;
    w_glow     = '0;
    for (int i = 0; i < 8; i++) begin
      w_led_nxt[i] = (r_duty[i] == MAX) || (r_pwm_cnt < r_duty[i]);
      w_glow[i]    = !led_in[i] && (r_duty[i] != '0);
      if (led_in[i]) begin
        w_duty_nxt[i] = w_bright_nxt;
      end else begin
        if (w_fade_tick && (r_duty[i] != '0)) begin
          w_base = r_duty[i] - PWM_BITS'(1);
        end else begin
          w_base = r_duty[i];
        end
        w_duty_nxt[i] = (w_base < w_bright_nxt) ? w_base : w_bright_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_pre     <= '0;
      r_bright  <= MAX;
      r_duty    <= '0;
      r_led_out <= '0;
      r_fading  <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_pre     <= w_fade_tick ? '0 : r_pre + PRE_W'(1);
      r_bright  <= w_bright_nxt;
      r_duty    <= w_duty_nxt;
      r_led_out <= w_led_nxt;
      r_fading  <= |w_glow;
    end
  end

  assign led_out = r_led_out;
  assign fading  = r_fading;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver (PWM_BITS=4, FADE_DIV=4): vector table, directed
// corner sequences and random stimulus against an arithmetic reference model.
module tb_led_fade_driver;

  localparam int FD   = 4;
  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led_in;
  logic       bright_up;
  logic       bright_dn;
  logic [7:0] led_out;
  logic       fading;

  led_fade_driver #(.PWM_BITS(4), .FADE_DIV(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .led_in    (led_in),
    .bright_up (bright_up),
    .bright_dn (bright_dn),
    .led_out   (led_out),
    .fading    (fading)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: edges since reset, brightness and per-channel duty.
  int         m_cyc;
  int         m_bright;
  int         m_duty[8];
  logic [7:0] m_led;
  logic       m_fad;

  typedef struct {
    logic [7:0] li;
    logic       up;
    logic       dn;
    logic [7:0] exp_led;
    logic       exp_fad;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_bright = MAXV;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    m_led = '0;
    m_fad = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] li, input logic up, input logic dn);
    int pwm;
    bit tick;
    pwm  = m_cyc % 16;
    tick = ((m_cyc % FD) == FD - 1);
    m_fad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_led[i] = (m_duty[i] == MAXV) || (pwm < m_duty[i]);
      if (!li[i] && m_duty[i] > 0) m_fad = 1'b1;
    end
    if (up && !dn && m_bright < MAXV) m_bright++;
    else if (dn && !up && m_bright > 0) m_bright--;
    for (int i = 0; i < 8; i++) begin
      if (li[i]) m_duty[i] = m_bright;
      else if (tick && m_duty[i] > 0) m_duty[i] = (m_duty[i] - 1 < m_bright) ? m_duty[i] - 1 : m_bright;
      else m_duty[i] = (m_duty[i] < m_bright) ? m_duty[i] : m_bright;
    end
    m_cyc++;
  endtask

  task automatic step(input logic [7:0] li, input logic up, input logic dn, input bit check_model);
    led_in    = li;
    bright_up = up;
    bright_dn = dn;
    @(posedge clk);
    model_edge(li, up, dn);
    #2;
    if (check_model) begin
      chk("model_led_out", int'(led_out), int'(m_led));
      chk("model_fading", int'(fading), int'(m_fad));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    led_in    = '0;
    bright_up = 1'b0;
    bright_dn = 1'b0;
    #1;
    model_reset();
    chk("reset_led_out", int'(led_out), 0);
    chk("reset_fading", int'(fading), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    bit seen_fade;
    bit ok;
    logic [7:0] pat;
    int hold;
    logic up, dn;

    reset = 1'b1; led_in = '0; bright_up = 1'b0; bright_dn = 1'b0;

    // Hand-derived vectors: fade ticks on edges 4,8,12; pwm before edge n is n-1.
    tbl[0]  = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1};
    tbl[3]  = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1};
    tbl[5]  = '{8'h00, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[7]  = '{8'h02, 1'b0, 1'b0, 8'h01, 1'b1};
    tbl[8]  = '{8'h00, 1'b1, 1'b1, 8'h03, 1'b1};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 8'h03, 1'b1};
    tbl[12] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].li, tbl[i].up, tbl[i].dn, 1'b0);
      chk($sformatf("tbl%0d_led_out", i), int'(led_out), int'(tbl[i].exp_led));
      chk($sformatf("tbl%0d_fading", i), int'(fading), int'(tbl[i].exp_fad));
    end

    // Steady full-brightness channel
    do_reset();
    ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(8'h01, 1'b0, 1'b0, 1'b1);
      if (i >= 1 && (led_out !== 8'h01 || fading !== 1'b0)) ok = 1'b0;
    end
    chk("steady_full_on", int'(ok), 1);

    // Brightness 7: seven high cycles per 16-cycle period
    for (int i = 0; i < 8; i++) begin
      step(8'h01, 1'b0, 1'b1, 1'b1);
      step(8'h01, 1'b0, 1'b0, 1'b1);
    end
    step(8'h01, 1'b0, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'h01, 1'b0, 1'b0, 1'b1);
      cnt += int'(led_out[0]);
    end
    chk("bright7_high_cycles", cnt, 7);

    // Full fade from 15 to 0
    do_reset();
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b0, 1'b1);
    n = 0; seen_fade = 1'b0;
    do begin
      step(8'h00, 1'b0, 1'b0, 1'b1);
      n++;
      if (fading) seen_fade = 1'b1;
    end while ((fading || led_out[0]) && n < 100);
    chk("fade_seen", int'(seen_fade), 1);
    chk("fade_len_in_range", int'(n >= 56 && n <= 64), 1);

    // Brightness saturation at both ends and simultaneous up/dn
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(8'hFF, 1'b1, 1'b0, 1'b1);
      step(8'hFF, 1'b0, 1'b0, 1'b1);
    end
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b0, 1'b0, 1'b1);
      cnt += int'(led_out == 8'hFF);
    end
    chk("sat_max_all_on", cnt, 16);
    for (int i = 0; i < 20; i++) begin
      step(8'hFF, 1'b0, 1'b1, 1'b1);
      step(8'hFF, 1'b0, 1'b0, 1'b1);
    end
    step(8'hFF, 1'b1, 1'b1, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b0, 1'b0, 1'b1);
      cnt += int'(led_out != 8'h00);
    end
    chk("sat_min_all_off", cnt, 0);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b0, 1'b0, 1'b1);
      cnt += int'(led_out[3]);
    end
    chk("bright1_high_cycles", cnt, 1);

    // Reset asserted between edges in the middle of a fade
    do_reset();
    for (int i = 0; i < 5; i++) step(8'h01, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b0, 1'b1);
    n = 0;
    do begin
      step(8'h00, 1'b0, 1'b0, 1'b1);
      n++;
    end while (m_duty[0] != 8 && n < 100);
    chk("midfade_reached_duty8", m_duty[0], 8);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("midfade_fading_before_reset", int'(fading), 1);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midfade_reset_led_out", int'(led_out), 0);
    chk("midfade_reset_fading", int'(fading), 0);
    @(negedge clk);
    reset = 1'b0;
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b0, 1'b0, 1'b1);
      cnt += int'(led_out == 8'hFF);
    end
    chk("post_reset_bright_max", cnt, 16);

    // Walking one, then re-hit channel 0 while it is still glowing
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) step(8'h01 << k, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) step(8'h01 << k, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(8'h01, 1'b0, 1'b0, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(8'h01, 1'b0, 1'b0, 1'b1);
      if (!led_out[0]) ok = 1'b0;
    end
    chk("rehit_reload_full", int'(ok), 1);

    // Random patterns and brightness pulses
    do_reset();
    pat = 8'h00; hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        pat  = 8'($urandom);
        hold = $urandom_range(1, 40);
      end
      hold--;
      up = ($urandom_range(0, 9) == 0);
      dn = ($urandom_range(0, 7) == 0);
      step(pat, up, dn, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
